// File: rtl/imm_ext_arbiter.sv
// Round-robin share of the 16->32 immediate extender between decode and branch unit.
// Optional IMM_EXT_BRANCH_EN enables the shifted branch-displacement mode (11).
module imm_ext_arbiter #(
  parameter int IMM_W   = 16,
  parameter int DATA_W  = 32,
  parameter int RR_INIT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [IMM_W-1:0]  req_imm0,
  input  logic [IMM_W-1:0]  req_imm1,
  input  logic [1:0]        req_mode0,
  input  logic [1:0]        req_mode1,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_id
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam int PAD_W = DATA_W - IMM_W;

  state_t              r_state;
  logic [DATA_W-1:0]   r_data;
  logic                r_id;
  logic                r_prio;

  logic                w_can_accept;
  logic                w_gnt;
  logic                w_fire;
  logic [IMM_W-1:0]    w_imm;
  logic [1:0]          w_mode;
  logic                w_sign;
  logic [DATA_W-1:0]   w_ext;

  assign resp_valid = (r_state == FULL);
  assign resp_data  = r_data;
  assign resp_id    = r_id;

  assign w_can_accept = (r_state == EMPTY) || (resp_valid && resp_ready);

  always_comb begin
    w_gnt = r_prio;
    unique case (1'b1)
      (req_valid == 2'b01): w_gnt = 1'b0;
      (req_valid == 2'b10): w_gnt = 1'b1;
      default:              w_gnt = r_prio;
    endcase
  end

  // Ready is forced low while reset is asserted, independent of state.
  always_comb begin
    req_ready = 2'b00;
    if (rst_n && w_can_accept) begin
      req_ready[0] = req_valid[0] && !w_gnt;
      req_ready[1] = req_valid[1] &&  w_gnt;
    end
  end

  assign w_fire = |(req_valid & req_ready);

  assign w_imm  = w_gnt ? req_imm1  : req_imm0;
  assign w_mode = w_gnt ? req_mode1 : req_mode0;
  assign w_sign = w_imm[IMM_W-1];

  always_comb begin
    w_ext = {{PAD_W{w_sign}}, w_imm};
    unique case (w_mode)
      2'b00: w_ext = {{PAD_W{w_sign}}, w_imm};
      2'b01: w_ext = {{PAD_W{1'b0}}, w_imm};
      2'b10: w_ext = {w_imm, {PAD_W{1'b0}}};
`ifdef IMM_EXT_BRANCH_EN
      2'b11: w_ext = {{(PAD_W-2){w_sign}}, w_imm, 2'b00};
`else
      2'b11: w_ext = {{PAD_W{w_sign}}, w_imm};
`endif
      default: w_ext = {{PAD_W{w_sign}}, w_imm};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_data  <= '0;
      r_id    <= 1'b0;
      r_prio  <= RR_INIT[0];
    end else if (w_fire) begin
      r_state <= FULL;
      r_data  <= w_ext;
      r_id    <= w_gnt;
      r_prio  <= ~w_gnt;
    end else if (resp_valid && resp_ready) begin
      r_state <= EMPTY;
    end
  end

endmodule

// File: doc/imm_ext_arbiter.md
# imm_ext_arbiter

- Shares the processor's single 16→32-bit immediate extension resource between two requesters:
  - requester 0: decode stage, ALU/load/store immediates;
  - requester 1: branch-target unit, branch offsets.
- Round-robin arbitration with a valid/ready handshake on each request port.
- Selects the extension mode and registers the 32-bit result into a one-entry response buffer tagged with the requester id.
- Sits between the instruction decoder/branch unit and the ALU operand mux.

## Interface
Parameters:
- IMM_W, 16, immediate field width.
- DATA_W, 32, result width; must equal 2*IMM_W.
- RR_INIT, 0, requester holding priority after reset (0 or 1).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req_valid  in  2  per-requester request valid (bit i = requester i).
- req_ready  out  2  per-requester accept.
- req_imm0, req_imm1  in  IMM_W  immediate field from each requester.
- req_mode0, req_mode1  in  2  extension mode from each requester: 00 sign, 01 zero, 10 upper, 11 branch.
- resp_valid  out  1  result buffer holds a valid result.
- resp_ready  in  1  consumer accepts result.
- resp_data  out  DATA_W  extended result.
- resp_id  out  1  requester that produced resp_data.

## Operation
- States:
  - EMPTY: buffer empty.
  - FULL: buffer holds a result.
- Accept condition is `can_accept = (state==EMPTY) || (resp_valid && resp_ready)`. Ready depends combinationally on resp_ready.
- Grant:
  - Only one req_valid bit high: that requester is granted.
  - Both high: the requester equal to the priority pointer `prio` is granted.
  - `req_ready[g] = can_accept && req_valid[g]`. The non-granted bit is 0.
  - A request fires when `req_valid[i] && req_ready[i]`.
- On fire:
  - resp_data ← ext(imm_g, mode_g).
  - resp_id ← g.
  - State → FULL.
  - `prio ← ~g`. prio toggles away from the winner on every fire, including uncontested fires.
- Result drained with no new fire: state → EMPTY. resp_data and resp_id hold their last value.
- Extension rules, with imm[15] as the sign bit:
  - 00: {{16{imm[15]}}, imm}.
  - 01: {16'h0, imm}.
  - 10: {imm, 16'h0}.
  - 11: {{14{imm[15]}}, imm, 2'b00}, a word-offset branch displacement. This mode is subject to the macro in Configuration.
- Requesters must hold req_imm/req_mode stable while req_valid is high and not accepted. A dropped valid before accept is legal and discards the request.

## Timing
- Reset values (async, immediate on rst_n low):
  - state = EMPTY.
  - resp_valid = 0.
  - resp_data = 0.
  - resp_id = 0.
  - prio = RR_INIT.
  - req_ready = 0 while rst_n is low.
- Latency: request fire at edge N → resp_valid=1 and data valid after edge N (cycle N+1).
- Throughput: 1 result per cycle when resp_ready is held high. Drain and refill occur in the same edge.
- Backpressure: resp_ready=0 in FULL → req_ready=00. resp_data/resp_id stable until the drain.
- Fairness: with both requesters continuously valid and resp_ready=1, grants alternate 0,1,0,1… starting at RR_INIT.
- Reset mid-operation: a pending result is discarded with no response. The first grant after release follows RR_INIT.

## Configuration
- IMM_EXT_BRANCH_EN:
  - Defined: mode 11 produces the shifted branch displacement above.
  - Undefined: mode 11 is decoded as mode 00 (plain sign extension). The port list is unchanged.

## Test plan
- Reset, then req_valid=01, imm0=16'h8001, mode0=00, resp_ready=1:
  - req_ready=01 on the fire cycle;
  - next cycle resp_valid=1, resp_data=32'hFFFF8001, resp_id=0.
- Mode sweep on requester 1 with imm1=16'hF234:
  - mode 01 → 32'h0000F234;
  - mode 10 → 32'hF2340000;
  - mode 11 → 32'hFFFFC8D0 with the macro defined, 32'hFFFFF234 without it.
- Both valid continuously for 6 cycles with RR_INIT=0 and resp_ready=1 → resp_id sequence 0,1,0,1,0,1, one result per cycle.
- Backpressure:
  - Fire on requester 0, then hold resp_ready=0 for 3 cycles: req_ready=00 and resp_data held constant.
  - Raise resp_ready with req_valid=10 → drain and requester-1 fire on the same edge; the next result is valid the following cycle.
- Pull rst_n low while FULL, mid-cycle:
  - resp_valid drops immediately and resp_data reads 0.
  - After release with both requesters valid, the first resp_id equals RR_INIT.
